// File: rtl/sid_reg_writer.sv
// sid_reg_writer: FIFO-buffered initiator of SID register write cycles.
// Define SID_WR_SUPPRESS_EN to skip writes repeating a register's last value.
module sid_reg_writer #(
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 1
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   clk_en,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [4:0]             cmd_addr,
  input  logic [7:0]             cmd_data,
  input  logic                   flush,
  output logic [4:0]             sid_addr,
  output logic [7:0]             sid_data,
  output logic                   sid_n_cs,
  output logic                   sid_rw,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_TICKS);
  localparam logic [GW-1:0] GAP_LAST = GW'(1);
  localparam logic [4:0]    ADDR_MAX = 5'h18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [12:0]   r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_level;
  logic [AW:0]   w_level_nxt;
  logic          r_full;
  logic          r_drop;
  logic [GW-1:0] r_gap;
  logic [4:0]    r_addr;
  logic [7:0]    r_data;
  logic          r_n_cs;
  logic          r_rw;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_strobe;
  logic          w_gap_load;
  logic          w_gap_dec;
  logic          w_same;
  logic [4:0]    w_head_addr;
  logic [7:0]    w_head_data;

  assign w_accept = cmd_valid && !r_full;
  assign w_push   = w_accept && (cmd_addr <= ADDR_MAX) && !flush;
  assign {w_head_addr, w_head_data} = r_mem[r_head];

  assign cmd_ready  = !r_full;
  assign fifo_level = r_level;
  assign drop       = r_drop;
  assign sid_addr   = r_addr;
  assign sid_data   = r_data;
  assign sid_n_cs   = r_n_cs;
  assign sid_rw     = r_rw;
  assign busy       = (r_level != '0) || (r_state != S_IDLE);

`ifdef SID_WR_SUPPRESS_EN
  logic [7:0]  r_shadow [25];
  logic [24:0] r_shv;

  always_comb begin
    w_same = 1'b0;
    if (w_head_addr <= ADDR_MAX)
      w_same = r_shv[w_head_addr] &&
               (r_shadow[w_head_addr] == w_head_data);
  end

  // Valid bits survive flush; only reset forgets the shadow.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_shv <= '0;
    end else if (w_strobe) begin
      r_shv[w_head_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_strobe)
      r_shadow[w_head_addr] <= w_head_data;
  end
`else
  assign w_same = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_strobe    = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_dec   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (clk_en && (r_level != '0) && !flush) begin
          w_pop = 1'b1;
          if (!w_same) begin
            w_strobe    = 1'b1;
            w_state_nxt = S_STROBE;
          end
        end
      end
      S_STROBE: begin
        w_gap_load  = 1'b1;
        w_state_nxt = (GAP_TICKS > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (clk_en) begin
          w_gap_dec = 1'b1;
          if (r_gap == GAP_LAST)
            w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_level_nxt = r_level;
    if (flush)
      w_level_nxt = '0;
    else if (w_push && !w_pop)
      w_level_nxt = r_level + 1'b1;
    else if (!w_push && w_pop)
      w_level_nxt = r_level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_tail] <= {cmd_addr, cmd_data};
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_drop  <= w_accept && (cmd_addr > ADDR_MAX);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + 1'b1;
        if (w_pop)  r_head <= r_head + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_n_cs  <= 1'b1;
      r_rw    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_gap_load)
        r_gap <= GAP_LOAD;
      else if (w_gap_dec)
        r_gap <= r_gap - 1'b1;
      if (w_strobe) begin
        r_addr <= w_head_addr;
        r_data <= w_head_data;
        r_n_cs <= 1'b0;
        r_rw   <= 1'b0;
      end else if (r_state == S_STROBE) begin
        r_n_cs <= 1'b1;
        r_rw   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sid_reg_writer.sv
// tb_sid_reg_writer: directed bench for the SID write initiator.
// Strobes are logged at negedges and checked against hand-derived tables.
module tb_sid_reg_writer;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          clk_en = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [4:0]    cmd_addr = '0;
  logic [7:0]    cmd_data = '0;
  logic          flush = 1'b0;
  logic [4:0]    sid_addr;
  logic [7:0]    sid_data;
  logic          sid_n_cs;
  logic          sid_rw;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          drop;

  always #5 clk = ~clk;

  sid_reg_writer #(.DEPTH(DEPTH), .GAP_TICKS(1)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .clk_en     (clk_en),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .flush      (flush),
    .sid_addr   (sid_addr),
    .sid_data   (sid_data),
    .sid_n_cs   (sid_n_cs),
    .sid_rw     (sid_rw),
    .busy       (busy),
    .fifo_level (fifo_level),
    .drop       (drop)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rw_err = 0;
  int stab_err = 0;
  int mode = 0;
  int ph = 0;

  logic       prev_en = 1'b0;
  logic [4:0] prev_addr = '0;
  logic [7:0] prev_data = '0;
  logic [4:0] lg_addr [$];
  logic [7:0] lg_data [$];
  int         lg_cyc [$];
  logic       lg_en [$];

  // Strobe logger; prev_en is the clk_en the strobing edge sampled.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (n_reset) begin
      if (sid_n_cs !== sid_rw) rw_err <= rw_err + 1;
      if (sid_n_cs === 1'b0) begin
        lg_addr.push_back(sid_addr);
        lg_data.push_back(sid_data);
        lg_cyc.push_back(cyc + 1);
        lg_en.push_back(prev_en);
      end else if (sid_addr !== prev_addr ||
                   sid_data !== prev_data) begin
        stab_err <= stab_err + 1;
      end
    end
    prev_addr <= sid_addr;
    prev_data <= sid_data;
    prev_en   <= clk_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ph++;
    case (mode)
      0: clk_en = 1'b0;
      1: clk_en = 1'b1;
      default: clk_en = (ph % 8 == 0);
    endcase
  endtask

  task automatic clear_log();
    lg_addr.delete();
    lg_data.delete();
    lg_cyc.delete();
    lg_en.delete();
  endtask

  task automatic push(input logic [4:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (3) tick();
    n_reset = 1'b1;
    tick();
    n_cmp += 8;
    if (sid_n_cs !== 1'b1) begin
      n_bad++; $display("FAIL reset_ncs got %b want 1", sid_n_cs);
    end
    if (sid_rw !== 1'b1) begin
      n_bad++; $display("FAIL reset_rw got %b want 1", sid_rw);
    end
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready got %b want 1", cmd_ready);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got %b want 0", busy);
    end
    if (fifo_level !== '0) begin
      n_bad++; $display("FAIL reset_level got %0d want 0", fifo_level);
    end
    if (drop !== 1'b0) begin
      n_bad++; $display("FAIL reset_drop got %b want 0", drop);
    end
    if (sid_addr !== 5'h00) begin
      n_bad++; $display("FAIL reset_addr got %h want 00", sid_addr);
    end
    if (sid_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_data got %h want 00", sid_data);
    end
  endtask

  task automatic test_two_writes();
    int t0;
    mode = 1;
    tick();
    clear_log();
    cmd_valid = 1'b1;
    cmd_addr  = 5'h18;
    cmd_data  = 8'h0F;
    tick();
    t0 = cyc;
    cmd_addr = 5'h04;
    cmd_data = 8'h11;
    tick();
    cmd_valid = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (lg_addr.size() != 2) begin
      n_bad++;
      $display("FAIL two_count got %0d want 2", lg_addr.size());
    end else begin
      n_cmp += 6;
      if (lg_addr[0] !== 5'h18 || lg_data[0] !== 8'h0F) begin
        n_bad++;
        $display("FAIL two_first got %h/%h want 18/0f",
                 lg_addr[0], lg_data[0]);
      end
      if (lg_addr[1] !== 5'h04 || lg_data[1] !== 8'h11) begin
        n_bad++;
        $display("FAIL two_second got %h/%h want 04/11",
                 lg_addr[1], lg_data[1]);
      end
      if (lg_cyc[0] != t0 + 2) begin
        n_bad++;
        $display("FAIL two_latency got %0d want %0d", lg_cyc[0], t0 + 2);
      end
      if (lg_cyc[1] - lg_cyc[0] != 3) begin
        n_bad++;
        $display("FAIL two_spacing got %0d want 3",
                 lg_cyc[1] - lg_cyc[0]);
      end
      if (busy !== 1'b0) begin
        n_bad++; $display("FAIL two_busy got %b want 0", busy);
      end
      if (fifo_level !== '0) begin
        n_bad++; $display("FAIL two_level got %0d want 0", fifo_level);
      end
    end
  endtask

  task automatic test_slow_enable();
    logic [4:0] ea [3];
    logic [7:0] ed [3];
    ea[0] = 5'h02; ea[1] = 5'h03; ea[2] = 5'h05;
    ed[0] = 8'h31; ed[1] = 8'h32; ed[2] = 8'h33;
    mode = 2;
    tick();
    clear_log();
    for (int i = 0; i < 3; i++) push(ea[i], ed[i]);
    repeat (70) tick();
    n_cmp++;
    if (lg_addr.size() != 3) begin
      n_bad++;
      $display("FAIL slow_count got %0d want 3", lg_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp += 2;
        if (lg_addr[i] !== ea[i] || lg_data[i] !== ed[i]) begin
          n_bad++;
          $display("FAIL slow_order[%0d] got %h/%h want %h/%h",
                   i, lg_addr[i], lg_data[i], ea[i], ed[i]);
        end
        if (lg_en[i] !== 1'b1) begin
          n_bad++;
          $display("FAIL slow_on_en[%0d] got %b want 1", i, lg_en[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (lg_cyc[i] - lg_cyc[i-1] != 16) begin
          n_bad++;
          $display("FAIL slow_spacing[%0d] got %0d want 16",
                   i, lg_cyc[i] - lg_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_full_and_wrap();
    mode = 0;
    tick();
    clear_log();
    cmd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cmd_addr = 5'(i);
      cmd_data = 8'hA0 + 8'(i);
      tick();
    end
    cmd_valid = 1'b0;
    n_cmp += 3;
    if (cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_ready got %b want 0", cmd_ready);
    end
    if (fifo_level !== LW'(16)) begin
      n_bad++; $display("FAIL full_level got %0d want 16", fifo_level);
    end
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL full_busy got %b want 1", busy);
    end
    push(5'h10, 8'hEE);
    n_cmp += 2;
    if (fifo_level !== LW'(16)) begin
      n_bad++; $display("FAIL full_refuse got %0d want 16", fifo_level);
    end
    if (drop !== 1'b0) begin
      n_bad++; $display("FAIL full_drop got %b want 0", drop);
    end
    mode = 1;
    repeat (60) tick();
    n_cmp++;
    if (lg_addr.size() != 16) begin
      n_bad++;
      $display("FAIL drain_count got %0d want 16", lg_addr.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (lg_addr[i] !== 5'(i) || lg_data[i] !== 8'hA0 + 8'(i)) begin
          n_bad++;
          $display("FAIL drain_order[%0d] got %h/%h want %h/%h",
                   i, lg_addr[i], lg_data[i], 5'(i), 8'hA0 + 8'(i));
        end
      end
    end
    n_cmp++;
    if (cmd_ready !== 1'b1 || fifo_level !== '0) begin
      n_bad++;
      $display("FAIL drain_empty got ready=%b lvl=%0d want 1/0",
               cmd_ready, fifo_level);
    end
    clear_log();
    for (int i = 0; i < 5; i++) push(5'h10 + 5'(i), 8'h50 + 8'(i));
    repeat (20) tick();
    n_cmp++;
    if (lg_addr.size() != 5) begin
      n_bad++;
      $display("FAIL refill_count got %0d want 5", lg_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (lg_addr[i] !== 5'h10 + 5'(i) ||
            lg_data[i] !== 8'h50 + 8'(i)) begin
          n_bad++;
          $display("FAIL refill_order[%0d] got %h/%h", i,
                   lg_addr[i], lg_data[i]);
        end
      end
    end
  endtask

  task automatic test_drop();
    int n0;
    mode = 1;
    tick();
    n0 = lg_addr.size();
    push(5'h19, 8'h55);
    n_cmp += 2;
    if (drop !== 1'b1) begin
      n_bad++; $display("FAIL drop_19 got %b want 1", drop);
    end
    if (fifo_level !== '0) begin
      n_bad++; $display("FAIL drop_19_level got %0d want 0", fifo_level);
    end
    tick();
    n_cmp++;
    if (drop !== 1'b0) begin
      n_bad++; $display("FAIL drop_clear1 got %b want 0", drop);
    end
    push(5'h1F, 8'h66);
    n_cmp += 2;
    if (drop !== 1'b1) begin
      n_bad++; $display("FAIL drop_1f got %b want 1", drop);
    end
    if (fifo_level !== '0) begin
      n_bad++; $display("FAIL drop_1f_level got %0d want 0", fifo_level);
    end
    tick();
    n_cmp++;
    if (drop !== 1'b0) begin
      n_bad++; $display("FAIL drop_clear2 got %b want 0", drop);
    end
    repeat (5) tick();
    n_cmp++;
    if (lg_addr.size() != n0) begin
      n_bad++;
      $display("FAIL drop_nostrobe got %0d want %0d", lg_addr.size(), n0);
    end
  endtask

  task automatic test_flush_in_gap();
    mode = 0;
    tick();
    clear_log();
    for (int i = 0; i < 6; i++) push(5'h08 + 5'(i), 8'h60 + 8'(i));
    clk_en = 1'b1;
    tick();
    n_cmp += 2;
    if (sid_n_cs !== 1'b0) begin
      n_bad++; $display("FAIL flush_strobe got %b want 0", sid_n_cs);
    end
    if (fifo_level !== LW'(5)) begin
      n_bad++; $display("FAIL flush_pre got %0d want 5", fifo_level);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp += 3;
    if (fifo_level !== '0) begin
      n_bad++; $display("FAIL flush_level got %0d want 0", fifo_level);
    end
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_ready got %b want 1", cmd_ready);
    end
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL flush_gap_busy got %b want 1", busy);
    end
    mode = 1;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_busy_fall got %b want 0", busy);
    end
    repeat (5) tick();
    n_cmp++;
    if (lg_addr.size() != 1 || lg_addr[0] !== 5'h08) begin
      n_bad++;
      $display("FAIL flush_strobes got %0d want 1", lg_addr.size());
    end
  endtask

  task automatic hold_reset();
    n_reset = 1'b0;
    @(negedge clk);
    #1;
    n_reset = 1'b1;
  endtask

  task automatic test_async_reset();
    mode = 1;
    tick();
    push(5'h0A, 8'h77);
    tick();
    n_cmp++;
    if (sid_n_cs !== 1'b0) begin
      n_bad++; $display("FAIL areset_pre got %b want 0", sid_n_cs);
    end
    #2;
    n_reset = 1'b0;
    #1;
    n_cmp += 4;
    if (sid_n_cs !== 1'b1 || sid_rw !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_bus got ncs=%b rw=%b want 1/1",
               sid_n_cs, sid_rw);
    end
    if (sid_addr !== 5'h00 || sid_data !== 8'h00) begin
      n_bad++;
      $display("FAIL areset_ad got %h/%h want 00/00", sid_addr, sid_data);
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL areset_busy got %b want 0", busy);
    end
    if (fifo_level !== '0) begin
      n_bad++; $display("FAIL areset_level got %0d want 0", fifo_level);
    end
    @(negedge clk);
    #1;
    n_reset = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (sid_n_cs !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_after got ncs=%b busy=%b want 1/0",
               sid_n_cs, busy);
    end
  endtask

`ifdef SID_WR_SUPPRESS_EN
  task automatic test_suppress();
    mode = 1;
    tick();
    clear_log();
    push(5'h01, 8'h22);
    repeat (6) tick();
    push(5'h01, 8'h22);
    repeat (6) tick();
    n_cmp += 2;
    if (lg_addr.size() != 1) begin
      n_bad++; $display("FAIL supp_repeat got %0d want 1", lg_addr.size());
    end
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL supp_busy got %b want 0", busy);
    end
    push(5'h01, 8'h23);
    repeat (6) tick();
    n_cmp++;
    if (lg_addr.size() != 2) begin
      n_bad++; $display("FAIL supp_change got %0d want 2", lg_addr.size());
    end
    hold_reset();
    tick();
    push(5'h01, 8'h22);
    repeat (6) tick();
    n_cmp++;
    if (lg_addr.size() != 3 || lg_data[2] !== 8'h22) begin
      n_bad++;
      $display("FAIL supp_after_reset got %0d want 3", lg_addr.size());
    end
  endtask
`endif

  task automatic test_bus_integrity();
    n_cmp += 2;
    if (rw_err != 0) begin
      n_bad++; $display("FAIL rw_follows_ncs got %0d want 0", rw_err);
    end
    if (stab_err != 0) begin
      n_bad++; $display("FAIL bus_stable got %0d want 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_two_writes();
    test_slow_enable();
    test_full_and_wrap();
    test_drop();
    test_flush_in_gap();
    test_async_reset();
`ifdef SID_WR_SUPPRESS_EN
    test_suppress();
`endif
    test_bus_integrity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
